// File: rtl/tsn_pkt_defs.sv
// Shared packet-bus definitions: word width, flag encodings, field positions
// and the input arbiter's state encoding.
package tsn_pkt_defs;

    localparam int PKT_W   = 134;
    localparam int FLAG_HI = 133;
    localparam int FLAG_LO = 132;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    localparam logic [3:0] INV_ALL = 4'd15;

    // Tail synthesised when a packet arrives without its own tail word
    localparam logic [PKT_W-1:0] FORCED_TAIL = {FLAG_TAIL, INV_ALL, 128'd0};

    typedef enum logic [1:0] {
        IDLE_S  = 2'b00,
        TRAN_S  = 2'b01,
        FLUSH_S = 2'b10
    } arb_state_e;

    function automatic logic [1:0] pkt_flag(input logic [PKT_W-1:0] word);
        return word[FLAG_HI:FLAG_LO];
    endfunction

endpackage

// File: rtl/pkt_rr_sel.sv
// Combinational round-robin picker: returns the first requesting port after
// ptr, wrapping modulo PORT_NUM (ptr itself is checked last).
module pkt_rr_sel #(
    parameter int PORT_NUM = 4,
    parameter int PORT_W   = 2
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [PORT_W-1:0]   ptr,
    output logic                valid,
    output logic [PORT_W-1:0]   idx
);

    // Scan ptr+1 .. ptr+PORT_NUM and keep the first hit
    always_comb begin
        logic [PORT_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            cand = PORT_W'((int'(ptr) + i) % PORT_NUM);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/pkt_input_arbiter.sv
// Round-robin packet arbiter merging PORT_NUM show-ahead FIFO streams onto one
// pkt bus. Whole packets are granted, words are never interleaved, malformed
// flag sequences are dropped (orphans) or closed with a forced tail.
// Optional feature macro: PKT_ARB_CNT_EN adds per-port completed-packet
// counters on ov_pkt_cnt (and the CNT_W parameter).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE_S  | choose next port; head -> grant, orphan word -> drop + o_err
// TRAN_S  | stream granted port's words until tail; stray head -> FLUSH_S
// FLUSH_S | emit forced tail when downstream ready, then back to IDLE_S
module pkt_input_arbiter
    import tsn_pkt_defs::*;
#(
    parameter int PORT_NUM = 4,
    parameter int PORT_W   = 2
`ifdef PKT_ARB_CNT_EN
   ,parameter int CNT_W    = 16
`endif
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [PORT_NUM-1:0]       iv_fifo_empty,
    input  logic [PORT_NUM*PKT_W-1:0] iv_fifo_rdata,
    output logic [PORT_NUM-1:0]       ov_fifo_rd,
    input  logic                      i_out_ready,
    output logic                      o_pkt_wr,
    output logic [PKT_W-1:0]          ov_pkt,
    output logic [PORT_W-1:0]         ov_src_port,
    output logic                      o_err,
    output logic [1:0]                arb_state
`ifdef PKT_ARB_CNT_EN
   ,output logic [PORT_NUM*CNT_W-1:0] ov_pkt_cnt
`endif
);

    arb_state_e        state;
    logic [PORT_W-1:0] grant;
    logic [PORT_W-1:0] rr_ptr;
    logic              first_word;

    logic              sel_valid;
    logic [PORT_W-1:0] sel_idx;
    logic [1:0]        sel_flag;
    logic [PKT_W-1:0]  gnt_word;
    logic [1:0]        gnt_flag;
    logic              gnt_avail;
    logic              stray_head;
    logic              idle_drop;
    logic              tran_pop;

    pkt_rr_sel #(
        .PORT_NUM (PORT_NUM),
        .PORT_W   (PORT_W)
    ) u_rr_sel (
        .req   (~iv_fifo_empty),
        .ptr   (rr_ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign sel_flag   = iv_fifo_rdata[int'(sel_idx)*PKT_W + FLAG_LO +: 2];
    assign gnt_word   = iv_fifo_rdata[int'(grant)*PKT_W +: PKT_W];
    assign gnt_flag   = pkt_flag(gnt_word);
    assign gnt_avail  = !iv_fifo_empty[grant];
    // A head after the first popped word means the previous packet lost its tail
    assign stray_head = (gnt_flag == FLAG_HEAD) && !first_word;
    assign idle_drop  = (state == IDLE_S) && sel_valid && (sel_flag != FLAG_HEAD);
    assign tran_pop   = (state == TRAN_S) && gnt_avail && i_out_ready && !stray_head;
    assign arb_state  = state;

    // One-hot pop strobe; held off during reset so nothing is lost while it is asserted
    always_comb begin
        ov_fifo_rd = '0;
        if (!reset) begin
            if (idle_drop) begin
                ov_fifo_rd[sel_idx] = 1'b1;
            end else if (tran_pop) begin
                ov_fifo_rd[grant] = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered output word, source port and error pulse
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE_S;
            grant       <= '0;
            rr_ptr      <= PORT_W'(PORT_NUM - 1);
            first_word  <= 1'b0;
            o_pkt_wr    <= 1'b0;
            ov_pkt      <= '0;
            ov_src_port <= '0;
            o_err       <= 1'b0;
        end else begin
            o_pkt_wr <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                IDLE_S: begin
                    if (sel_valid) begin
                        if (sel_flag == FLAG_HEAD) begin
                            grant      <= sel_idx;
                            first_word <= 1'b1;
                            state      <= TRAN_S;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                TRAN_S: begin
                    if (tran_pop) begin
                        o_pkt_wr    <= 1'b1;
                        ov_pkt      <= gnt_word;
                        ov_src_port <= grant;
                        first_word  <= 1'b0;
                        if (gnt_flag == FLAG_TAIL) begin
                            rr_ptr <= grant;
                            state  <= IDLE_S;
                        end
                    end else if (gnt_avail && stray_head) begin
                        state <= FLUSH_S;
                    end
                end
                FLUSH_S: begin
                    if (i_out_ready) begin
                        o_pkt_wr    <= 1'b1;
                        ov_pkt      <= FORCED_TAIL;
                        ov_src_port <= grant;
                        o_err       <= 1'b1;
                        rr_ptr      <= grant;
                        state       <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

`ifdef PKT_ARB_CNT_EN
    logic tail_emit;

    assign tail_emit = (tran_pop && (gnt_flag == FLAG_TAIL)) ||
                       ((state == FLUSH_S) && i_out_ready);

    // Completed packets per port, real or forced tail; wraps naturally
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ov_pkt_cnt <= '0;
        end else if (tail_emit) begin
            ov_pkt_cnt[int'(grant)*CNT_W +: CNT_W] <=
                ov_pkt_cnt[int'(grant)*CNT_W +: CNT_W] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_input_arbiter.sv
// Bench for pkt_input_arbiter: per-port FIFO queues drive the DUT, a
// packet-level reference model predicts the merged word stream and error count.
// Build with PKT_ARB_CNT_EN to also check the per-port counters (CNT_W=4 here).
module tb_pkt_input_arbiter;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int W  = 134;
    localparam int CW = 4;

    localparam logic [1:0] F_HEAD = 2'b01;
    localparam logic [1:0] F_MID  = 2'b11;
    localparam logic [1:0] F_TAIL = 2'b10;
    localparam logic [W-1:0] F_FORCED = {2'b10, 4'hF, 128'h0};

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [N-1:0]    iv_fifo_empty;
    logic [N*W-1:0]  iv_fifo_rdata;
    logic [N-1:0]    ov_fifo_rd;
    logic            i_out_ready;
    logic            o_pkt_wr;
    logic [W-1:0]    ov_pkt;
    logic [PW-1:0]   ov_src_port;
    logic            o_err;
    logic [1:0]      arb_state;
`ifdef PKT_ARB_CNT_EN
    logic [N*CW-1:0] ov_pkt_cnt;
`endif

    pkt_input_arbiter #(
        .PORT_NUM (N),
        .PORT_W   (PW)
`ifdef PKT_ARB_CNT_EN
       ,.CNT_W    (CW)
`endif
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .iv_fifo_empty (iv_fifo_empty),
        .iv_fifo_rdata (iv_fifo_rdata),
        .ov_fifo_rd    (ov_fifo_rd),
        .i_out_ready   (i_out_ready),
        .o_pkt_wr      (o_pkt_wr),
        .ov_pkt        (ov_pkt),
        .ov_src_port   (ov_src_port),
        .o_err         (o_err),
        .arb_state     (arb_state)
`ifdef PKT_ARB_CNT_EN
       ,.ov_pkt_cnt    (ov_pkt_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    logic [W-1:0]    q  [N][$];
    logic [W-1:0]    mq [N][$];
    logic [PW+W-1:0] exp_q[$];
    bit              wr_log[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              mptr;
    int              exp_err;
    int              err_seen;
    int              exp_tails[N];
    int              n_wr;
    int              stall_cnt;
    int              ready_mode;
    logic            prev_rdy;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        for (int p = 0; p < N; p++) begin
            iv_fifo_empty[p] = (q[p].size() == 0);
            iv_fifo_rdata[p*W +: W] = (q[p].size() > 0) ? q[p][0] : '0;
        end
    endtask

    task automatic add_word(input int p, input logic [1:0] flag);
        logic [W-1:0] w;
        w = {flag, 4'($urandom_range(0, 15)), $urandom(), $urandom(), $urandom(), $urandom()};
        q[p].push_back(w);
        mq[p].push_back(w);
    endtask

    task automatic add_pkt(input int p, input int nmid);
        add_word(p, F_HEAD);
        for (int i = 0; i < nmid; i++) add_word(p, F_MID);
        add_word(p, F_TAIL);
    endtask

    // Packet-level reference: consume model queues in round-robin packet order
    task automatic model();
        int c;
        bit found;
        logic [W-1:0] w;
        exp_err = 0;
        while (1) begin
            found = 0;
            c = 0;
            for (int i = 1; i <= N; i++) begin
                if (!found && mq[(mptr + i) % N].size() > 0) begin
                    found = 1;
                    c = (mptr + i) % N;
                end
            end
            if (!found) break;
            w = mq[c].pop_front();
            if (w[W-1:W-2] != F_HEAD) begin
                exp_err++;
                continue;
            end
            exp_q.push_back({PW'(c), w});
            while (mq[c].size() > 0) begin
                w = mq[c][0];
                if (w[W-1:W-2] == F_HEAD) begin
                    exp_q.push_back({PW'(c), F_FORCED});
                    exp_err++;
                    exp_tails[c]++;
                    mptr = c;
                    break;
                end
                void'(mq[c].pop_front());
                exp_q.push_back({PW'(c), w});
                if (w[W-1:W-2] == F_TAIL) begin
                    exp_tails[c]++;
                    mptr = c;
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] rd;
        logic [PW+W-1:0] e;
        @(negedge clk_sys);
        wr_log.push_back(o_pkt_wr);
        if (o_pkt_wr) begin
            n_wr++;
            chk("wr_after_not_ready", prev_rdy, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", o_pkt_wr, 0);
            end else begin
                e = exp_q.pop_front();
                chk("word", ov_pkt, e[W-1:0]);
                chk("src_port", ov_src_port, e[PW+W-1:W]);
            end
            if (ready_mode == 2 && n_wr == 2) stall_cnt = 3;
        end
        if (o_err) err_seen++;
        if (ov_fifo_rd != '0) begin
            chk("rd_onehot", $countones(ov_fifo_rd) <= 1, 1);
            chk("rd_nonempty", |(ov_fifo_rd & iv_fifo_empty), 0);
        end
        rd = ov_fifo_rd;
        prev_rdy = i_out_ready;
        @(posedge clk_sys);
        #1;
        for (int p = 0; p < N; p++) begin
            if (rd[p] && q[p].size() > 0) void'(q[p].pop_front());
        end
        if (ready_mode == 1) begin
            i_out_ready = ($urandom_range(0, 3) != 0);
        end else if (stall_cnt > 0) begin
            i_out_ready = 1'b0;
            stall_cnt--;
        end else begin
            i_out_ready = 1'b1;
        end
        drive_ports();
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < N; p++) if (q[p].size() != 0) return 0;
        return 1;
    endfunction

    task automatic run_scn(input int rmode);
        int cyc;
        int idle;
        model();
        ready_mode = rmode;
        n_wr = 0;
        err_seen = 0;
        stall_cnt = 0;
        wr_log.delete();
        drive_ports();
        cyc = 0;
        idle = 0;
        while (idle < 6 && cyc < 4000) begin
            cycle();
            cyc++;
            if (all_empty() && exp_q.size() == 0) idle++;
            else idle = 0;
        end
        chk("done_in_budget", cyc < 4000, 1);
        chk("words_left", exp_q.size(), 0);
        chk("err_count", err_seen, exp_err);
`ifdef PKT_ARB_CNT_EN
        for (int p = 0; p < N; p++)
            chk("pkt_cnt", ov_pkt_cnt[p*CW +: CW], exp_tails[p] % (1 << CW));
`endif
        exp_q.delete();
        i_out_ready = 1'b1;
    endtask

    task automatic gen_random();
        int npk;
        for (int p = 0; p < N; p++) begin
            npk = $urandom_range(1, 4);
            for (int k = 0; k < npk; k++) begin
                if ($urandom_range(0, 9) == 0) add_word(p, ($urandom_range(0, 1) != 0) ? F_MID : F_TAIL);
                add_word(p, F_HEAD);
                for (int m = $urandom_range(0, 3); m > 0; m--) add_word(p, F_MID);
                if (!(k < npk - 1 && $urandom_range(0, 6) == 0)) add_word(p, F_TAIL);
            end
        end
    endtask

    bit s1_pat[7] = '{0, 0, 1, 1, 1, 1, 0};

    initial begin
        reset = 1'b1;
        i_out_ready = 1'b1;
        prev_rdy = 1'b1;
        mptr = N - 1;
        foreach (exp_tails[p]) exp_tails[p] = 0;
        drive_ports();
        #1;
        chk("rst_wr", o_pkt_wr, 0);
        chk("rst_pkt", ov_pkt, 0);
        chk("rst_src", ov_src_port, 0);
        chk("rst_err", o_err, 0);
        chk("rst_state", arb_state, 0);
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1 reset = 1'b0;

        // single 4-word packet: bubble then 4 back-to-back words
        add_pkt(0, 2);
        run_scn(0);
        chk("s1_len", wr_log.size() >= 7, 1);
        if (wr_log.size() >= 7)
            for (int i = 0; i < 7; i++) chk("s1_wr_timing", wr_log[i], s1_pat[i]);

        // all ports, two packets each
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++) add_pkt(p, $urandom_range(0, 3));
        run_scn(0);

        // downstream stall after word 2
        add_pkt(0, 2);
        run_scn(2);

        // orphan mid on port 2 in idle
        add_word(2, F_MID);
        add_pkt(2, 1);
        run_scn(0);

        // missing tail on port 1
        add_word(1, F_HEAD);
        add_word(1, F_MID);
        add_pkt(1, 0);
        run_scn(0);

        // randomized traffic under random backpressure
        for (int r = 0; r < 4; r++) begin
            gen_random();
            run_scn(1);
        end

        // reset in the middle of a packet
        add_pkt(1, 1);
        run_scn(0);
        add_pkt(2, 5);
        model();
        ready_mode = 0;
        n_wr = 0;
        drive_ports();
        for (int k = 0; k < 40 && n_wr < 2; k++) cycle();
        chk("rst_pre_words", n_wr, 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wr", o_pkt_wr, 0);
        chk("mid_rst_pkt", ov_pkt, 0);
        chk("mid_rst_src", ov_src_port, 0);
        chk("mid_rst_err", o_err, 0);
        chk("mid_rst_state", arb_state, 0);
        chk("mid_rst_rd", ov_fifo_rd, 0);
`ifdef PKT_ARB_CNT_EN
        chk("mid_rst_cnt", ov_pkt_cnt, 0);
`endif
        for (int p = 0; p < N; p++) begin
            q[p].delete();
            mq[p].delete();
        end
        exp_q.delete();
        foreach (exp_tails[p]) exp_tails[p] = 0;
        mptr = N - 1;
        drive_ports();
        @(posedge clk_sys);
        #1 reset = 1'b0;
        add_pkt(3, 1);
        add_pkt(0, 2);
        run_scn(0);

`ifdef PKT_ARB_CNT_EN
        // counter wrap on port 0
        for (int k = 0; k < 17; k++) add_pkt(0, 0);
        run_scn(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
